// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage. Owns the PC, issues req/rdy fetches
//                to a variable-latency instruction memory, presents one
//                registered instruction per cycle with valid/stall flow
//                control, one-entry skid buffer, redirect flush and HLT stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HLT_OPC  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus2,
    output logic              fetch_halted
);

    localparam logic [ADDR_W-1:0] c_pc_step    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(1);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_HOLD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t             r_state,      w_state_nx;
    logic [ADDR_W-1:0]  r_pc,         w_pc_nx;
    logic               r_req,        w_req_nx;
    logic [ADDR_W-1:0]  r_addr,       w_addr_nx;
    logic               r_valid,      w_valid_nx;
    logic [DATA_W-1:0]  r_instr,      w_instr_nx;
    logic [ADDR_W-1:0]  r_if_pc,      w_if_pc_nx;
    logic [ADDR_W-1:0]  r_if_pc2,     w_if_pc2_nx;
    logic               r_skid_valid, w_skid_valid_nx;
    logic [DATA_W-1:0]  r_skid_instr, w_skid_instr_nx;
    logic [ADDR_W-1:0]  r_skid_pc,    w_skid_pc_nx;

    logic               w_slot_free;
    logic               w_consume;
    logic               w_data_hlt;
    logic               w_skid_hlt;
    logic [ADDR_W-1:0]  w_redir_pc;
    logic [ADDR_W-1:0]  w_pc_inc;

    assign w_slot_free = !r_valid || !stall;
    assign w_consume   = r_valid && !stall;
    assign w_data_hlt  = (imem_data[DATA_W-1 -: 4] == HLT_OPC);
    assign w_skid_hlt  = (r_skid_instr[DATA_W-1 -: 4] == HLT_OPC);
    assign w_redir_pc  = redirect_pc & c_align_mask;
    assign w_pc_inc    = r_pc + c_pc_step;

    always_comb begin
        w_state_nx      = r_state;
        w_pc_nx         = r_pc;
        w_req_nx        = r_req;
        w_addr_nx       = r_addr;
        w_valid_nx      = r_valid;
        w_instr_nx      = r_instr;
        w_if_pc_nx      = r_if_pc;
        w_if_pc2_nx     = r_if_pc2;
        w_skid_valid_nx = r_skid_valid;
        w_skid_instr_nx = r_skid_instr;
        w_skid_pc_nx    = r_skid_pc;

        if (w_consume) begin
            w_valid_nx = 1'b0;
        end

        if (redirect) begin
            // Flush beats stall; an unanswered request must still be drained.
            w_pc_nx         = w_redir_pc;
            w_valid_nx      = 1'b0;
            w_skid_valid_nx = 1'b0;
            if (r_req && !imem_rdy) begin
                w_state_nx = S_DRAIN;
            end else begin
                w_state_nx = S_REQ;
                w_req_nx   = 1'b0;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (!r_req) begin
                        w_req_nx  = 1'b1;
                        w_addr_nx = r_pc;
                    end else if (imem_rdy) begin
                        w_pc_nx = w_pc_inc;
                        if (w_slot_free) begin
                            w_valid_nx  = 1'b1;
                            w_instr_nx  = imem_data;
                            w_if_pc_nx  = r_addr;
                            w_if_pc2_nx = r_addr + c_pc_step;
                            if (w_data_hlt) begin
                                w_state_nx = S_HALTED;
                                w_req_nx   = 1'b0;
                            end else begin
                                w_req_nx  = 1'b1;
                                w_addr_nx = w_pc_inc;
                            end
                        end else begin
                            w_skid_valid_nx = 1'b1;
                            w_skid_instr_nx = imem_data;
                            w_skid_pc_nx    = r_addr;
                            w_state_nx      = S_HOLD;
                            w_req_nx        = 1'b0;
                        end
                    end
                end

                S_HOLD: begin
                    if (w_slot_free) begin
                        w_valid_nx      = 1'b1;
                        w_instr_nx      = r_skid_instr;
                        w_if_pc_nx      = r_skid_pc;
                        w_if_pc2_nx     = r_skid_pc + c_pc_step;
                        w_skid_valid_nx = 1'b0;
                        w_state_nx      = w_skid_hlt ? S_HALTED : S_REQ;
                    end
                end

                S_DRAIN: begin
                    if (imem_rdy) begin
                        w_req_nx   = 1'b0;
                        w_state_nx = S_REQ;
                    end
                end

                S_HALTED: begin
                    w_req_nx = 1'b0;
                end

                default: begin
                    w_state_nx = S_REQ;
                    w_req_nx   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC & c_align_mask;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_if_pc      <= '0;
            r_if_pc2     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_req        <= w_req_nx;
            r_addr       <= w_addr_nx;
            r_valid      <= w_valid_nx;
            r_instr      <= w_instr_nx;
            r_if_pc      <= w_if_pc_nx;
            r_if_pc2     <= w_if_pc2_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_skid_instr <= w_skid_instr_nx;
            r_skid_pc    <= w_skid_pc_nx;
        end
    end

    assign imem_req     = r_req;
    assign imem_addr    = r_addr;
    assign if_valid     = r_valid;
    assign if_instr     = r_instr;
    assign if_pc        = r_if_pc;
    assign if_pc_plus2  = r_if_pc2;
    assign fetch_halted = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        fetch_halted;

    logic [15:0] hlt_addr;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Memory image: HLT at hlt_addr, otherwise opcode A with the low address bits.
    assign imem_data = (imem_addr == hlt_addr) ? 16'hF000 : {4'hA, imem_addr[11:0]};

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdy     (imem_rdy),
        .imem_data    (imem_data),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc_plus2  (if_pc_plus2),
        .fetch_halted (fetch_halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] instr,
                             input logic [15:0] pc, input logic [15:0] pc2);
        check({tag, ".valid"}, 32'(if_valid), 32'(v));
        check({tag, ".instr"}, 32'(if_instr), 32'(instr));
        check({tag, ".pc"},    32'(if_pc),    32'(pc));
        check({tag, ".pc2"},   32'(if_pc_plus2), 32'(pc2));
    endtask

    task automatic check_req(input string tag, input logic req, input logic [15:0] addr);
        check({tag, ".req"}, 32'(imem_req), 32'(req));
        if (req) check({tag, ".addr"}, 32'(imem_addr), 32'(addr));
    endtask

    initial begin
        rst         = 1'b0;
        imem_rdy    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        stall       = 1'b0;
        hlt_addr    = 16'h0006;

        // 1: reset, rdy tied high, back-to-back fetch up to HLT at 6
        tick();
        check_out("rst", 1'b0, 16'h0000, 16'h0000, 16'h0000);
        check("rst.req", 32'(imem_req), 32'd0);
        check("rst.addr", 32'(imem_addr), 32'd0);
        check("rst.halted", 32'(fetch_halted), 32'd0);
        rst = 1'b1;
        tick();
        check_req("t1.first", 1'b1, 16'h0000);
        check("t1.first.valid", 32'(if_valid), 32'd0);
        tick();
        check_out("t1.pc0", 1'b1, 16'hA000, 16'h0000, 16'h0002);
        tick();
        check_out("t1.pc2", 1'b1, 16'hA002, 16'h0002, 16'h0004);
        tick();
        check_out("t1.pc4", 1'b1, 16'hA004, 16'h0004, 16'h0006);
        tick();
        check_out("t1.pc6", 1'b1, 16'hF000, 16'h0006, 16'h0008);
        check("t1.halt.req", 32'(imem_req), 32'd0);
        check("t1.halted", 32'(fetch_halted), 32'd1);
        tick();
        check("t1.consumed.valid", 32'(if_valid), 32'd0);
        check("t1.consumed.halted", 32'(fetch_halted), 32'd1);
        check("t1.consumed.req", 32'(imem_req), 32'd0);

        // 2: redirect out of HALTED to 0x0100, then 3-cycle memory latency
        imem_rdy    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check("t2.unhalt", 32'(fetch_halted), 32'd0);
        check("t2.redir.req", 32'(imem_req), 32'd0);
        tick();
        check_req("t2.req100", 1'b1, 16'h0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_req("t2.wait100", 1'b1, 16'h0100);
            check("t2.wait100.valid", 32'(if_valid), 32'd0);
        end
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        check_out("t2.ret100", 1'b1, 16'hA100, 16'h0100, 16'h0102);
        check_req("t2.req102", 1'b1, 16'h0102);
        tick();
        check("t2.pulse.valid", 32'(if_valid), 32'd0);
        tick();
        check_req("t2.wait102", 1'b1, 16'h0102);
        check("t2.wait102.valid", 32'(if_valid), 32'd0);
        tick();
        imem_rdy = 1'b1;
        tick();
        check_out("t2.ret102", 1'b1, 16'hA102, 16'h0102, 16'h0104);

        // 3: stall for 4 cycles, return lands in the skid buffer
        imem_rdy = 1'b0;
        stall    = 1'b1;
        tick();
        check_out("t3.stall1", 1'b1, 16'hA102, 16'h0102, 16'h0104);
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        check_out("t3.skidfill", 1'b1, 16'hA102, 16'h0102, 16'h0104);
        check("t3.skidfill.req", 32'(imem_req), 32'd0);
        tick();
        tick();
        check_out("t3.stall4", 1'b1, 16'hA102, 16'h0102, 16'h0104);
        check("t3.stall4.req", 32'(imem_req), 32'd0);
        stall = 1'b0;
        tick();
        check_out("t3.skidout", 1'b1, 16'hA104, 16'h0104, 16'h0106);
        check("t3.skidout.req", 32'(imem_req), 32'd0);
        tick();
        check_req("t3.req106", 1'b1, 16'h0106);
        check("t3.req106.valid", 32'(if_valid), 32'd0);
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        check_out("t3.ret106", 1'b1, 16'hA106, 16'h0106, 16'h0108);

        // 4: redirect with same-cycle return, then redirect during an outstanding request
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        imem_rdy    = 1'b1;
        tick();
        redirect = 1'b0;
        imem_rdy = 1'b0;
        check("t4.flush.valid", 32'(if_valid), 32'd0);
        check("t4.flush.req", 32'(imem_req), 32'd0);
        tick();
        check_req("t4.req010", 1'b1, 16'h0010);
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        tick();
        redirect = 1'b0;
        check_req("t4.drain", 1'b1, 16'h0010);
        check("t4.drain.valid", 32'(if_valid), 32'd0);
        tick();
        check_req("t4.drain2", 1'b1, 16'h0010);
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        check("t4.dropped.valid", 32'(if_valid), 32'd0);
        check("t4.dropped.req", 32'(imem_req), 32'd0);
        tick();
        check_req("t4.req040", 1'b1, 16'h0040);
        check("t4.req040.valid", 32'(if_valid), 32'd0);
        tick();
        check("t4.wait040.valid", 32'(if_valid), 32'd0);
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        check_out("t4.ret040", 1'b1, 16'hA040, 16'h0040, 16'h0042);

        // 5: speculative HLT at 0x0042 flushed by redirect under stall
        hlt_addr = 16'h0042;
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        stall    = 1'b1;
        check_out("t5.hlt", 1'b1, 16'hF000, 16'h0042, 16'h0044);
        check("t5.halted", 32'(fetch_halted), 32'd1);
        tick();
        check("t5.hold.valid", 32'(if_valid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("t5.flush.valid", 32'(if_valid), 32'd0);
        check("t5.flush.halted", 32'(fetch_halted), 32'd0);
        tick();
        check_req("t5.req020", 1'b1, 16'h0020);
        imem_rdy = 1'b1;
        tick();
        imem_rdy = 1'b0;
        check_out("t5.ret020", 1'b1, 16'hA020, 16'h0020, 16'h0022);

        // 6: wrap at 0xFFFE, then reset while a request waits
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        imem_rdy    = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        check_req("t6.reqFFFE", 1'b1, 16'hFFFE);
        tick();
        imem_rdy = 1'b0;
        check_out("t6.retFFFE", 1'b1, 16'hAFFE, 16'hFFFE, 16'h0000);
        check_req("t6.wrap", 1'b1, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        check_out("t6.rst", 1'b0, 16'h0000, 16'h0000, 16'h0000);
        check("t6.rst.req", 32'(imem_req), 32'd0);
        check("t6.rst.addr", 32'(imem_addr), 32'd0);
        check("t6.rst.halted", 32'(fetch_halted), 32'd0);
        rst      = 1'b1;
        imem_rdy = 1'b1;
        tick();
        check("t6.late.valid", 32'(if_valid), 32'd0);
        check_req("t6.restart", 1'b1, 16'h0000);
        tick();
        check_out("t6.ret000", 1'b1, 16'hA000, 16'h0000, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
